expr_eval_ctrl: RTL and testbench

- Byte-stream controller that parses and evaluates single-digit arithmetic expressions of the form digit (op digit)* terminated by '='.
- op is '+' or '*'. '*' binds tighter than '+'.
- Sits between a character source (valid/ready) and a result consumer (valid/ready).
- Sequences an internal sum/term datapath and reports either the value or a syntax error per expression.

---
 rtl/expr_eval_ctrl.sv | 131 +++++++++++++
 tb/tb_expr_eval_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/expr_eval_ctrl.sv
// Streaming evaluator for digit (op digit)* '=' expressions.
// '*' binds tighter than '+'; one result or error per '='.
module expr_eval_ctrl #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [7:0]   in,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] res,
   output logic         res_err,
   output logic         res_valid,
   input  logic         res_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_OPND,
      S_OPER,
      S_ERR,
      S_DONE
   } state_t;

   state_t       r_state, w_state_nx;
   logic [W-1:0] r_sum, w_sum_nx;
   logic [W-1:0] r_term, w_term_nx;
   logic [W-1:0] r_res, w_res_nx;
   logic         r_mul, w_mul_nx;
   logic         r_err, w_err_nx;

   logic         w_acc;
   logic         w_is_dig;
   logic         w_is_op;
   logic         w_is_eq;
   logic [W-1:0] w_dig;
   logic [W-1:0] w_prod;

   assign in_ready  = (r_state != S_DONE);
   assign res_valid = (r_state == S_DONE);
   assign res       = r_res;
   assign res_err   = r_err;

   assign w_acc    = in_valid && in_ready;
   assign w_is_dig = (in >= 8'h30) && (in <= 8'h39);
   assign w_is_op  = (in == 8'h2B) || (in == 8'h2A);
   assign w_is_eq  = (in == 8'h3D);
   assign w_dig    = {{(W-4){1'b0}}, in[3:0]};
   assign w_prod   = r_term * w_dig;

   always_comb begin
      w_state_nx = r_state;
      w_sum_nx   = r_sum;
      w_term_nx  = r_term;
      w_res_nx   = r_res;
      w_mul_nx   = r_mul;
      w_err_nx   = r_err;
      if (r_state == S_DONE) begin
         if (res_ready) begin
            w_state_nx = S_IDLE;
            w_sum_nx   = '0;
            w_term_nx  = '0;
            w_mul_nx   = 1'b0;
         end
      end else if (w_acc) begin
         // Malformed expressions still end on '=' with a zeroed error result
         if (w_is_eq && (r_state != S_OPND)) begin
            w_state_nx = S_DONE;
            w_res_nx   = '0;
            w_err_nx   = 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_is_dig) begin
                     w_state_nx = S_OPND;
                     w_sum_nx   = '0;
                     w_term_nx  = w_dig;
                  end else begin
                     w_state_nx = S_ERR;
                  end
               end
               S_OPND: begin
                  if (w_is_op) begin
                     w_state_nx = S_OPER;
                     w_mul_nx   = (in == 8'h2A);
                  end else if (w_is_eq) begin
                     w_state_nx = S_DONE;
                     w_res_nx   = r_sum + r_term;
                     w_err_nx   = 1'b0;
                  end else begin
                     w_state_nx = S_ERR;
                  end
               end
               S_OPER: begin
                  if (w_is_dig) begin
                     w_state_nx = S_OPND;
                     if (r_mul) begin
                        w_term_nx = w_prod;
                     end else begin
                        w_sum_nx  = r_sum + r_term;
                        w_term_nx = w_dig;
                     end
                  end else begin
                     w_state_nx = S_ERR;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= S_IDLE;
         r_sum   <= '0;
         r_term  <= '0;
         r_res   <= '0;
         r_mul   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_sum   <= w_sum_nx;
         r_term  <= w_term_nx;
         r_res   <= w_res_nx;
         r_mul   <= w_mul_nx;
         r_err   <= w_err_nx;
      end
   end

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// Directed bench for expr_eval_ctrl with a result scoreboard.
module tb_expr_eval_ctrl;

   localparam int W = 16;

   logic         clk;
   logic         clr;
   logic [7:0]   in;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] res;
   logic         res_err;
   logic         res_valid;
   logic         res_ready;

   logic [W:0]   sb[$];
   int           n_cmp;
   int           n_bad;

   expr_eval_ctrl #(.W(W)) dut (
      .clk       (clk),
      .clr       (clr),
      .in        (in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .res       (res),
      .res_err   (res_err),
      .res_valid (res_valid),
      .res_ready (res_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Samples one time unit before each rising edge, i.e. the handshake view.
   always @(negedge clk) begin
      #4;
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
         logic [W:0] e;
         chk("result_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("res", 32'(res), 32'(e[W-1:0]));
            chk("res_err", 32'(res_err), 32'(e[W]));
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic put(input logic [7:0] c);
      int n;
      n = 0;
      in = c;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run(input string s, input logic e, input logic [W-1:0] v);
      sb.push_back({e, v});
      for (int i = 0; i < s.len(); i++) put(s[i]);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      clr = 1'b1;
      in = 8'h00;
      in_valid = 1'b0;
      res_ready = 1'b1;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_res", 32'(res), 32'd0);
      chk("rst_err", 32'(res_err), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);

      run("1+2*3=", 1'b0, 16'd7);
      chk("t1_valid", 32'(res_valid), 32'd1);
      chk("t1_ready_low", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("t1_ready_back", 32'(in_ready), 32'd1);
      chk("t1_valid_drop", 32'(res_valid), 32'd0);

      run("2*3*4+5=", 1'b0, 16'd29);
      run("8=", 1'b0, 16'd8);

      run("+1=", 1'b1, 16'd0);
      run("12=", 1'b1, 16'd0);
      run("3+=", 1'b1, 16'd0);
      run("=", 1'b1, 16'd0);
      run("4a+1=", 1'b1, 16'd0);

      run("9*9*9*9*9*9=", 1'b0, 16'd7153);

      @(negedge clk);
      res_ready = 1'b0;
      run("5+5=", 1'b0, 16'd10);
      in = "9";
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(res_valid), 32'd1);
         chk("stall_res", 32'(res), 32'd10);
         chk("stall_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      run("6+7=", 1'b0, 16'd13);

      @(negedge clk);
      put("7");
      put("*");
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_valid", 32'(res_valid), 32'd0);
      chk("clr_ready", 32'(in_ready), 32'd1);
      run("2=", 1'b0, 16'd2);

      @(negedge clk);
      res_ready = 1'b0;
      run("4=", 1'b0, 16'd4);
      chk("done_valid", 32'(res_valid), 32'd1);
      chk("done_res", 32'(res), 32'd4);
      void'(sb.pop_front());
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      res_ready = 1'b1;
      chk("clr_done_valid", 32'(res_valid), 32'd0);
      chk("clr_done_res", 32'(res), 32'd0);

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
